quadrature_decoder_capture: RTL and testbench

QUADRATURE_DECODER_CAPTURE -- requirements
Module: quadrature_decoder_capture

---
 rtl/qd_pkg.sv | 35 +++
 rtl/quadrature_decoder_capture_if.sv | 16 +
 rtl/qd_input_filter.sv | 49 ++++
 rtl/quadrature_decoder_capture.sv | 242 ++++++++++++++++++++++++
 tb/tb_quadrature_decoder_capture.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/qd_pkg.sv
// rtl/qd_pkg.sv - shared types and constants for the quadrature decoder/capture block
// Contents:
//   ERR_COUNT_W  width of the saturating illegal-transition counter
//   qd_mode_e    counting resolution (x1 / x2 / x4; code 3 behaves as x4)
//   qd_state_e   run-control FSM states
//   quad_phase   maps a filtered {A,B} pair to its position in the up cycle
package qd_pkg;

    localparam int ERR_COUNT_W = 8;

    typedef enum logic [1:0] {
        MODE_X1     = 2'd0,
        MODE_X2     = 2'd1,
        MODE_X4     = 2'd2,
        MODE_X4_ALT = 2'd3
    } qd_mode_e;

    typedef enum logic [1:0] {
        ST_DISABLED   = 2'd0,
        ST_WAIT_INDEX = 2'd1,
        ST_RUN        = 2'd2
    } qd_state_e;

    // Up cycle is 00 -> 10 -> 11 -> 01 -> 00, so the phase difference
    // (new - old, mod 4) is 1 for up, 3 for down and 2 for a double change.
    function automatic logic [1:0] quad_phase(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/quadrature_decoder_capture_if.sv
// rtl/quadrature_decoder_capture_if.sv - capture FIFO ready/valid handshake
// Signals:
//   cap_valid  head entry of the capture FIFO is valid
//   cap_ready  consumer accepts the head entry this cycle
//   cap_data   {direction, position} of the head entry
// Modports: master = decoder side (drives valid/data), slave = consumer side.
interface quadrature_decoder_capture_if #(
    parameter int POSITION_SIZE = 32
);
    logic                   cap_valid;
    logic                   cap_ready;
    logic [POSITION_SIZE:0] cap_data;

    modport master (output cap_valid, output cap_data, input cap_ready);
    modport slave  (input cap_valid, input cap_data, output cap_ready);
endinterface

// File: rtl/qd_input_filter.sv
// rtl/qd_input_filter.sv - 2-FF synchroniser followed by a consecutive-cycle debouncer
// Ports:
//   i_clk, i_areset  clock, async active-high reset
//   i_raw            asynchronous input line
//   i_dbnc_time      cycles the synchronised value must differ before the output follows
//   o_filt           filtered output (latency 2 + max(i_dbnc_time,1) cycles)
module qd_input_filter #(
    parameter int DBNC_SIZE = 8
) (
    input  logic                 i_clk,
    input  logic                 i_areset,
    input  logic                 i_raw,
    input  logic [DBNC_SIZE-1:0] i_dbnc_time,
    output logic                 o_filt
);

    logic                 r_meta;
    logic                 r_sync;
    logic                 r_filt;
    logic [DBNC_SIZE-1:0] r_cnt;
    logic [DBNC_SIZE:0]   w_cnt_inc;

    // One bit wider so the compare works at the all-ones debounce setting;
    // a setting of 0 satisfies the compare immediately (pass-through).
    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_filt) begin
                r_cnt <= '0;
            end else if (w_cnt_inc >= {1'b0, i_dbnc_time}) begin
                r_filt <= r_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= w_cnt_inc[DBNC_SIZE-1:0];
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/quadrature_decoder_capture.sv
// rtl/quadrature_decoder_capture.sv - quadrature encoder decoder with index homing and triggered position capture
// Ports:
//   i_clk, i_areset                 clock, async active-high reset
//   i_a, i_b, i_z                   raw encoder lines
//   enable, home_on_index           run enable; wait for first Z after enable
//   mode                            0=x1, 1=x2, 2/3=x4
//   clear                           clears sticky flags and error counter
//   dbnc_time                       debounce length in cycles
//   zero_position                   value loaded on reset and on Z
//   delta_size                      counted steps between triggers (0 = off)
//   steps_in_circle                 wrap modulus (0 = natural wrap)
//   absolute_position, direction    current position, 1 = last step up
//   step_toggle, trigger_out        toggles per counted step; trigger pulse
//   enable_status                   high in RUN
//   illegal_err, index_slip         sticky error flags
//   err_count                       saturating illegal-transition count
//   cap_overflow                    sticky, a trigger was dropped on full FIFO
//   cap                             capture FIFO output handshake
module quadrature_decoder_capture
    import qd_pkg::*;
#(
    parameter int POSITION_SIZE = 32,
    parameter int DBNC_SIZE     = 8,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_areset,
    input  logic                     i_a,
    input  logic                     i_b,
    input  logic                     i_z,
    input  logic                     enable,
    input  logic                     home_on_index,
    input  logic [1:0]               mode,
    input  logic                     clear,
    input  logic [DBNC_SIZE-1:0]     dbnc_time,
    input  logic [POSITION_SIZE-1:0] zero_position,
    input  logic [POSITION_SIZE-1:0] delta_size,
    input  logic [POSITION_SIZE-1:0] steps_in_circle,
    output logic [POSITION_SIZE-1:0] absolute_position,
    output logic                     direction,
    output logic                     step_toggle,
    output logic                     trigger_out,
    output logic                     enable_status,
    output logic                     illegal_err,
    output logic                     index_slip,
    output logic [ERR_COUNT_W-1:0]   err_count,
    output logic                     cap_overflow,
    quadrature_decoder_capture_if.master cap
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // ---------------- input conditioning ----------------
    logic w_a_f, w_b_f, w_z_f;

    qd_input_filter #(.DBNC_SIZE(DBNC_SIZE)) u_filt_a (
        .i_clk(i_clk), .i_areset(i_areset), .i_raw(i_a), .i_dbnc_time(dbnc_time), .o_filt(w_a_f));
    qd_input_filter #(.DBNC_SIZE(DBNC_SIZE)) u_filt_b (
        .i_clk(i_clk), .i_areset(i_areset), .i_raw(i_b), .i_dbnc_time(dbnc_time), .o_filt(w_b_f));
    qd_input_filter #(.DBNC_SIZE(DBNC_SIZE)) u_filt_z (
        .i_clk(i_clk), .i_areset(i_areset), .i_raw(i_z), .i_dbnc_time(dbnc_time), .o_filt(w_z_f));

    // ---------------- state ----------------
    qd_state_e                r_state;
    qd_state_e                w_state_next;
    logic                     r_a_q, r_b_q, r_z_q;
    logic [POSITION_SIZE-1:0] r_pos;
    logic                     r_dir;
    logic                     r_toggle;
    logic                     r_trigger;
    logic [POSITION_SIZE-1:0] r_dist;
    logic                     r_z_seen;
    logic                     r_illegal;
    logic                     r_slip;
    logic                     r_ovf;
    logic [ERR_COUNT_W-1:0]   r_err_count;

    // ---------------- edge decode ----------------
    logic [1:0] w_ab_old, w_ab_new, w_phase_diff;
    logic       w_z_rise;
    logic       w_counted;
    logic       w_step_up, w_step_dn, w_step;
    logic       w_illegal_evt;

    assign w_ab_old     = {r_a_q, r_b_q};
    assign w_ab_new     = {w_a_f, w_b_f};
    assign w_phase_diff = quad_phase(w_ab_new) - quad_phase(w_ab_old);
    assign w_z_rise     = w_z_f & ~r_z_q;

    // Which legal transitions contribute a count at the selected resolution.
    always_comb begin
        w_counted = 1'b1;
        case (qd_mode_e'(mode))
            MODE_X1: w_counted = (w_ab_old == 2'b00 && w_ab_new == 2'b10) ||
                                 (w_ab_old == 2'b10 && w_ab_new == 2'b00);
            MODE_X2: w_counted = w_ab_old[1] ^ w_ab_new[1];
            default: w_counted = 1'b1;
        endcase
    end

    // ---------------- run-control FSM ----------------
    logic w_count_en, w_enable_rise, w_z_load;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) r_state <= ST_DISABLED;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_DISABLED:   if (enable) w_state_next = home_on_index ? ST_WAIT_INDEX : ST_RUN;
            ST_WAIT_INDEX: if (!enable) w_state_next = ST_DISABLED;
                           else if (w_z_rise) w_state_next = ST_RUN;
            ST_RUN:        if (!enable) w_state_next = ST_DISABLED;
            default:       w_state_next = ST_DISABLED;
        endcase
    end

    always_comb begin
        w_enable_rise = (r_state == ST_DISABLED) && enable;
        w_count_en    = (r_state == ST_RUN) && enable;
        // Z homes in WAIT_INDEX and re-homes in RUN.
        w_z_load      = (r_state != ST_DISABLED) && enable && w_z_rise;
        enable_status = (r_state == ST_RUN);
    end

    assign w_step_up     = w_count_en && w_counted && (w_phase_diff == 2'd1);
    assign w_step_dn     = w_count_en && w_counted && (w_phase_diff == 2'd3);
    assign w_step        = w_step_up | w_step_dn;
    assign w_illegal_evt = w_count_en && (w_phase_diff == 2'd2);

    // ---------------- position arithmetic ----------------
    logic                     w_wrap_en;
    logic [POSITION_SIZE-1:0] w_pos_up, w_pos_dn;
    logic [POSITION_SIZE-1:0] w_dist_inc;
    logic                     w_trig_hit;

    assign w_wrap_en  = (steps_in_circle != '0);
    assign w_pos_up   = (w_wrap_en && r_pos == steps_in_circle - 1'b1) ? '0 : r_pos + 1'b1;
    assign w_pos_dn   = (w_wrap_en && r_pos == '0) ? steps_in_circle - 1'b1 : r_pos - 1'b1;
    assign w_dist_inc = r_dist + 1'b1;
    // A step swallowed by a Z load does not advance the trigger distance.
    assign w_trig_hit = w_step && !w_z_load && (delta_size != '0) && (w_dist_inc == delta_size);

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_a_q     <= 1'b0;
            r_b_q     <= 1'b0;
            r_z_q     <= 1'b0;
            r_pos     <= zero_position;
            r_dir     <= 1'b1;
            r_toggle  <= 1'b0;
            r_trigger <= 1'b0;
            r_dist    <= '0;
            r_z_seen  <= 1'b0;
        end else begin
            r_a_q     <= w_a_f;
            r_b_q     <= w_b_f;
            r_z_q     <= w_z_f;
            r_trigger <= w_trig_hit;
            if (w_z_load) begin
                r_pos    <= zero_position;
                r_dist   <= '0;
                r_z_seen <= 1'b1;
            end else if (w_step) begin
                r_pos    <= w_step_up ? w_pos_up : w_pos_dn;
                r_dir    <= w_step_up;
                r_toggle <= ~r_toggle;
                r_dist   <= w_trig_hit ? '0 : w_dist_inc;
            end
            if (w_enable_rise) begin
                r_dist   <= '0;
                r_z_seen <= 1'b0;
            end
        end
    end

    // ---------------- capture FIFO ----------------
    // Pushed from the registered trigger so the entry carries the position
    // shown alongside trigger_out and appears one cycle later.
    logic [POSITION_SIZE:0] r_mem [FIFO_DEPTH];
    logic [AW:0]            r_wptr, r_rptr;
    logic [AW:0]            w_fill;
    logic                   w_full, w_empty, w_pop, w_push_ok, w_ovf_evt;

    assign w_fill    = r_wptr - r_rptr;
    assign w_full    = (w_fill == (AW+1)'(FIFO_DEPTH));
    assign w_empty   = (r_wptr == r_rptr);
    assign w_pop     = !w_empty && cap.cap_ready;
    assign w_push_ok = r_trigger && (!w_full || w_pop);
    assign w_ovf_evt = r_trigger && w_full && !w_pop;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= {r_dir, r_pos};
    end

    assign cap.cap_valid = !w_empty;
    assign cap.cap_data  = r_mem[r_rptr[AW-1:0]];

    // ---------------- sticky status ----------------
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_illegal   <= 1'b0;
            r_slip      <= 1'b0;
            r_ovf       <= 1'b0;
            r_err_count <= '0;
        end else if (clear) begin
            r_illegal   <= 1'b0;
            r_slip      <= 1'b0;
            r_ovf       <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_illegal_evt) begin
                r_illegal <= 1'b1;
                if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
            end
            if (w_z_load && r_z_seen && r_pos != zero_position) r_slip <= 1'b1;
            if (w_ovf_evt) r_ovf <= 1'b1;
        end
    end

    assign absolute_position = r_pos;
    assign direction         = r_dir;
    assign step_toggle       = r_toggle;
    assign trigger_out       = r_trigger;
    assign illegal_err       = r_illegal;
    assign index_slip        = r_slip;
    assign err_count         = r_err_count;
    assign cap_overflow      = r_ovf;

endmodule

// File: tb/tb_quadrature_decoder_capture.sv
// tb/tb_quadrature_decoder_capture.sv - self-checking bench for quadrature_decoder_capture
module tb_quadrature_decoder_capture;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a, b, z, enable, home, clear;
    logic [1:0]    mode;
    logic [7:0]    dbnc;
    logic [PW-1:0] zero_pos, delta, sic;
    logic [PW-1:0] pos;
    logic          dir, tog, trig, en_st, ill, slip, ovf;
    logic [7:0]    errc;

    always #5 clk = ~clk;

    quadrature_decoder_capture_if #(.POSITION_SIZE(PW)) cap_if ();

    quadrature_decoder_capture #(.POSITION_SIZE(PW), .DBNC_SIZE(8), .FIFO_DEPTH(2)) dut (
        .i_clk(clk), .i_areset(rst), .i_a(a), .i_b(b), .i_z(z),
        .enable(enable), .home_on_index(home), .mode(mode), .clear(clear),
        .dbnc_time(dbnc), .zero_position(zero_pos), .delta_size(delta),
        .steps_in_circle(sic), .absolute_position(pos), .direction(dir),
        .step_toggle(tog), .trigger_out(trig), .enable_status(en_st),
        .illegal_err(ill), .index_slip(slip), .err_count(errc),
        .cap_overflow(ovf), .cap(cap_if.master));

    int n_checks = 0;
    int n_errors = 0;
    int trig_seen = 0;

    always @(negedge clk) if (trig === 1'b1) trig_seen++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: ideal encoder phase plus spec-level counting rules.
    logic [1:0] ab_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int m_idx, m_pos, m_dir, m_tog, m_dist, m_trigs, m_base;
    int m_mode, m_sic, m_delta;

    task automatic model_step(input bit up, input bit counting);
        logic [1:0] old_ab, new_ab;
        bit counted;
        old_ab = ab_seq[m_idx];
        m_idx  = up ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
        new_ab = ab_seq[m_idx];
        case (m_mode)
            0:       counted = (old_ab == 2'b00 && new_ab == 2'b10) || (old_ab == 2'b10 && new_ab == 2'b00);
            1:       counted = (old_ab[1] != new_ab[1]);
            default: counted = 1'b1;
        endcase
        if (counting && counted) begin
            if (m_sic != 0) m_pos = up ? (m_pos + 1) % m_sic : (m_pos + m_sic - 1) % m_sic;
            else            m_pos = up ? (m_pos + 1) % 65536 : (m_pos + 65535) % 65536;
            m_dir = up;
            m_tog = m_tog ^ 1;
            m_dist++;
            if (m_delta != 0 && m_dist == m_delta) begin
                m_trigs++;
                m_dist = 0;
            end
        end
        a = new_ab[1];
        b = new_ab[0];
    endtask

    task automatic do_step(input bit up, input bit counting);
        model_step(up, counting);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset(input int zp);
        rst = 1'b1;
        zero_pos = PW'(zp);
        enable = 0; home = 0; clear = 0; a = 0; b = 0; z = 0;
        cap_if.cap_ready = 0; mode = 2; dbnc = 1; delta = 0; sic = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_idx = 0; m_pos = zp; m_dir = 1; m_tog = 0; m_dist = 0; m_trigs = 0;
        m_base = trig_seen;
        @(negedge clk);
    endtask

    task automatic start(input int md, input int db, input int sc, input int dl, input bit hm);
        mode = 2'(md); dbnc = 8'(db); sic = PW'(sc); delta = PW'(dl); home = hm;
        m_mode = md; m_sic = sc; m_delta = dl;
        enable = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_z();
        z = 1; repeat (8) @(negedge clk);
        z = 0; repeat (8) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [PW-1:0] p0;

        // Reset state
        do_reset(7);
        check_eq("rst_pos", pos, 7);
        check_eq("rst_dir", dir, 1);
        check_eq("rst_tog", tog, 0);
        check_eq("rst_trig", trig, 0);
        check_eq("rst_cap_valid", cap_if.cap_valid, 0);
        check_eq("rst_flags", {ill, slip, ovf, en_st}, 0);
        check_eq("rst_errc", errc, 0);

        // x4, debounce 2: latency then two full cycles up and down
        do_reset(0);
        start(2, 2, 0, 0, 0);
        check_eq("run_status", en_st, 1);
        p0 = pos; n = 0;
        model_step(1, 1);
        while (n < 20 && pos === p0) begin @(posedge clk); #1; n++; end
        check_eq("latency_dbnc2", n, 5);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 7; i++) do_step(1, 1);
        check_eq("x4_up8", pos, 8);
        check_eq("x4_up_dir", dir, 1);
        for (int i = 0; i < 8; i++) do_step(0, 1);
        check_eq("x4_down8", pos, 0);
        check_eq("x4_down_dir", dir, 0);

        // x1 and x2
        do_reset(0);
        start(0, 2, 0, 0, 0);
        for (int i = 0; i < 8; i++) do_step(1, 1);
        check_eq("x1_up8", pos, 2);
        do_reset(0);
        start(1, 2, 0, 0, 0);
        for (int i = 0; i < 8; i++) do_step(1, 1);
        check_eq("x2_up8", pos, 4);

        // circle wrap
        do_reset(0);
        start(2, 1, 5, 0, 0);
        for (int i = 0; i < 6; i++) do_step(1, 1);
        check_eq("wrap_up", pos, 1);
        do_reset(0);
        start(2, 1, 5, 0, 0);
        do_step(0, 1);
        check_eq("wrap_down", pos, 4);
        do_reset(0);
        start(2, 0, 0, 0, 0);
        do_step(0, 1);
        check_eq("wrap_nat_down", pos, 16'hFFFF);

        // triggers, FIFO overflow, pop order, async reset discards
        do_reset(0);
        start(2, 1, 0, 3, 0);
        for (int i = 0; i < 9; i++) do_step(1, 1);
        check_eq("trig_count", trig_seen - m_base, 3);
        check_eq("trig_pos", pos, 9);
        check_eq("cap_ovf", ovf, 1);
        check_eq("cap_valid_full", cap_if.cap_valid, 1);
        check_eq("cap_head0", cap_if.cap_data, {1'b1, 16'd3});
        cap_if.cap_ready = 1;
        @(negedge clk);
        cap_if.cap_ready = 0;
        check_eq("cap_head1", cap_if.cap_data, {1'b1, 16'd6});
        check_eq("cap_valid_one", cap_if.cap_valid, 1);
        clear = 1; @(negedge clk); clear = 0; @(negedge clk);
        check_eq("ovf_clear", ovf, 0);
        rst = 1; #1;
        check_eq("areset_valid", cap_if.cap_valid, 0);
        check_eq("areset_pos", pos, 0);

        // homing on index and index slip
        do_reset(0);
        zero_pos = 10;
        start(2, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) do_step(1, 0);
        check_eq("home_ignored", pos, 0);
        check_eq("home_wait_status", en_st, 0);
        pulse_z();
        check_eq("home_load", pos, 10);
        check_eq("home_run_status", en_st, 1);
        check_eq("home_no_slip", slip, 0);
        m_pos = 10;
        for (int i = 0; i < 3; i++) do_step(1, 1);
        check_eq("home_count", pos, 13);
        pulse_z();
        check_eq("slip_set", slip, 1);
        check_eq("slip_pos", pos, 10);

        // illegal double transition and clear
        do_reset(0);
        start(2, 1, 0, 0, 0);
        a = 1; b = 1; m_idx = 2;
        repeat (8) @(negedge clk);
        check_eq("illegal_pos", pos, 0);
        check_eq("illegal_err", ill, 1);
        check_eq("illegal_cnt", errc, 1);
        clear = 1; @(negedge clk); clear = 0; @(negedge clk);
        check_eq("clear_err", ill, 0);
        check_eq("clear_cnt", errc, 0);
        do_step(1, 1);
        check_eq("after_illegal_step", pos, 1);

        // randomized runs against the model
        for (int r = 0; r < 4; r++) begin
            int md, db, sc, dl, zp;
            md = $urandom_range(0, 3);
            db = $urandom_range(0, 3);
            sc = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 12) : 0;
            dl = $urandom_range(0, 4);
            zp = (sc != 0) ? $urandom_range(0, sc - 1) : $urandom_range(0, 3);
            do_reset(zp);
            cap_if.cap_ready = 1;
            start(md, db, sc, dl, 0);
            for (int i = 0; i < 30; i++) begin
                do_step($urandom_range(0, 1) == 1, 1);
                check_eq("rnd_pos", pos, m_pos);
                check_eq("rnd_dir", dir, m_dir);
            end
            check_eq("rnd_tog", tog, m_tog);
            check_eq("rnd_trigs", trig_seen - m_base, m_trigs);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
